cache_fill_ctrl: RTL and testbench
==================================

# cache_fill_ctrl

Cache controller sitting between the CPU load/store path and the 128-byte direct-mapped cache (16-bit address, tag = address[15:7], index = address[6:0], w_rd: 0 = read, 1 = write, hit output, 8-bit bidirectional data). It issues the cache probes and decides hit or miss. On a read miss it fetches the byte from main memory over a req/ack handshake and writes it into the cache. CPU writes are write-through: cache first, then memory. It also keeps saturating hit and miss counters.

## Interface
- TIMEOUT, 255: maximum cycles mem_req may stay high without mem_ack (1..65535).
- clk  in  1  system clock; the cache is clocked by the same signal.
- rst  in  1  reset, asynchronous, active-high.
- cpu_req  in  1  request; held high until cpu_done.
- cpu_we  in  1  1 = write, 0 = read; captured at accept.
- cpu_addr  in  16  byte address; captured at accept.
- cpu_wdata  in  8  write data; captured at accept.
- cpu_rdata  out  8  read data; valid while cpu_done = 1.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_err  out  1  memory timeout; valid while cpu_done = 1.
- c_address  out  16  cache address.
- c_w_rd  out  1  cache write/read select.
- c_hit  in  1  cache hit flag.
- c_rdata  in  8  cache data bus (read view).
- c_wdata  out  8  data to drive onto the cache bus.
- c_data_oe  out  1  top level drives the cache data bus with c_wdata when 1.
- mem_req, mem_we  out  1  memory request; memory write select.
- mem_addr  out  16  memory address.
- mem_wdata  out  8  memory write data.
- mem_ack  in  1  memory acknowledge; read data valid in the same cycle.
- mem_rdata  in  8  memory read data.
- hit_cnt, miss_cnt  out  16  saturating read hit and read miss counters.

## Operation
- States: IDLE, PROBE, LOOKUP, FILL, MREQ, DONE.
- IDLE
  - cpu_req = 1 is accepted: latch addr, we, wdata.
  - If we = 0, go to PROBE. If we = 1, go to FILL with the write flag set.
  - cpu_req is ignored in every other state.
- PROBE: c_address = latched addr, c_w_rd = 0. Next state LOOKUP.
- LOOKUP
  - Sample c_hit; only an exact 1 counts as a hit (X or 0 is a miss).
  - Hit: capture c_rdata, hit_cnt++, go to DONE.
  - Miss: miss_cnt++, go to MREQ with mem_we = 0.
- MREQ
  - Drive mem_req = 1 and mem_addr = latched addr.
  - For writes, also drive mem_we = 1 and mem_wdata = latched wdata.
  - Hold all of these stable until mem_ack is sampled.
  - On ack, read: capture mem_rdata, go to FILL.
  - On ack, write: go to DONE.
  - A timeout counter loads 0 on MREQ entry and increments each cycle without ack. On count = TIMEOUT-1 with no ack: drop mem_req, set err, go to DONE. The cache is not written.
- FILL: c_address = latched addr, c_w_rd = 1, c_data_oe = 1.
  - c_wdata = fetched byte (read miss) or latched wdata (CPU write).
  - Read miss: next state DONE. CPU write: next state MREQ.
- DONE
  - cpu_done = 1; cpu_rdata = captured byte (0x00 on write or error).
  - cpu_err = err. Next state IDLE; err clears.
- c_data_oe is 1 only in FILL. In all other states c_w_rd = 0, and c_address holds its last value.
- mem_ack outside MREQ is ignored.
- Counters saturate at 0xFFFF and never wrap. Writes do not count.

## Timing
- Reset values (asserted asynchronously): state IDLE; every output 0, including c_w_rd = 0, c_data_oe = 0, mem_req = 0 and both counters.
- Reset during MREQ drops mem_req immediately. Reset during FILL drops c_data_oe immediately. No partial transaction resumes after reset.
- Accept edge = N.
  - Read hit: PROBE in cycle N, cache samples at N+1, LOOKUP in cycle N+1, cpu_done in cycle N+2. Hit latency is 2 cycles.
  - Read miss, ack sampled at edge M: FILL in cycle M, cache writes at M+1, cpu_done in cycle M+1.
  - Fastest miss: ack in the first MREQ cycle; cpu_done 4 cycles after accept.
  - Write: FILL in cycle N, MREQ from N+1, cpu_done in the cycle after the ack edge.
  - Timeout: mem_req high for exactly TIMEOUT cycles; cpu_done with cpu_err = 1 in the next cycle.
- Back-to-back requests: the earliest re-accept is the cycle after DONE. The CPU must drop cpu_req during DONE or it is accepted again.

## Test plan
- Hit on preloaded address:
  - Stimulus: after rst, read 0x0000.
  - Response: cpu_done 2 cycles after accept, cpu_rdata = 0x69, hit_cnt = 1, miss_cnt = 0, no mem_req.
- Read miss and fill:
  - Stimulus: read 0x1234; memory acks 3 cycles after mem_req with 0xA5.
  - Response: cpu_rdata = 0xA5, miss_cnt = 1.
  - A following read of 0x1234 hits with 0xA5 in 2 cycles.
- Write-through:
  - Stimulus: write 0x0080 = 0x5A.
  - Response: FILL for one cycle with c_wdata = 0x5A, then mem_req with mem_we = 1 and mem_addr = 0x0080 until ack.
  - A following read of 0x0080 hits with 0x5A.
- Timeout:
  - Stimulus: TIMEOUT = 4; read a miss address; mem_ack never asserted.
  - Response: mem_req high for exactly 4 cycles, then cpu_done with cpu_err = 1 and cpu_rdata = 0x00.
  - A re-read of the same address misses again.
- Reset mid-MREQ:
  - Stimulus: assert rst while mem_req = 1.
  - Response: mem_req, cpu_done and the counters go to 0 without waiting for a clock edge; a late mem_ack is ignored.
- Counter saturation:
  - Stimulus: force hit_cnt = 0xFFFE, then perform 3 hits.
  - Response: hit_cnt holds at 0xFFFF.

Source files
------------

// File: rtl/cache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_fill_ctrl
//
// Controller between the CPU load/store path and a 128-byte direct-mapped
// cache (tag = addr[15:7], index = addr[6:0]). Reads probe the cache and, on
// a miss, fetch the byte from main memory over a req/ack handshake and fill
// the cache line. Writes are write-through: the cache line is written first,
// then the byte is sent to memory. Read hits and read misses are tallied in
// saturating 16-bit counters.
//
// Ports
//   clk, rst                 system clock (shared with the cache), async
//                            active-high reset
//   cpu_req/we/addr/wdata    CPU request, held until cpu_done; fields are
//                            captured when the request is accepted in IDLE
//   cpu_rdata/done/err       one-cycle completion pulse with read data and
//                            memory-timeout flag
//   c_address/c_w_rd         cache address and write/read select
//   c_hit/c_rdata            cache hit flag and read data
//   c_wdata/c_data_oe        cache write data and bus drive enable
//   mem_req/we/addr/wdata    memory request, held until mem_ack
//   mem_ack/mem_rdata        memory acknowledge with same-cycle read data
//   hit_cnt/miss_cnt         saturating read hit / read miss counters
// -----------------------------------------------------------------------------
module cache_fill_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic [15:0] c_address,
    output logic        c_w_rd,
    input  logic        c_hit,
    input  logic [7:0]  c_rdata,
    output logic [7:0]  c_wdata,
    output logic        c_data_oe,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PROBE  = 3'd1,
        LOOKUP = 3'd2,
        FILL   = 3'd3,
        MREQ   = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q;
    state_t      state_d;

    logic [15:0] addr_q;
    logic        we_q;
    logic [7:0]  wdata_q;
    logic [7:0]  data_q;
    logic        err_q;
    logic [15:0] tmo_q;

    logic        accept;
    logic        hit_ev;
    logic        miss_ev;
    logic        ack_ev;
    logic        tmo_ev;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // The cache only ever sees the captured request address; between
    // transactions it simply keeps the last one.
    assign c_address = addr_q;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next state, outputs and per-cycle events
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        hit_ev    = 1'b0;
        miss_ev   = 1'b0;
        ack_ev    = 1'b0;
        tmo_ev    = 1'b0;
        cpu_rdata = 8'h00;
        cpu_done  = 1'b0;
        cpu_err   = 1'b0;
        c_w_rd    = 1'b0;
        c_wdata   = 8'h00;
        c_data_oe = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 16'h0000;
        mem_wdata = 8'h00;

        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    accept  = 1'b1;
                    state_d = cpu_we ? FILL : PROBE;
                end
            end

            PROBE: begin
                state_d = LOOKUP;
            end

            LOOKUP: begin
                // An X on c_hit takes the else branch, so it is a miss.
                if (c_hit == 1'b1) begin
                    hit_ev  = 1'b1;
                    state_d = DONE;
                end else begin
                    miss_ev = 1'b1;
                    state_d = MREQ;
                end
            end

            MREQ: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = we_q ? wdata_q : 8'h00;
                if (mem_ack) begin
                    ack_ev  = 1'b1;
                    state_d = we_q ? DONE : FILL;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_ev  = 1'b1;
                    state_d = DONE;
                end
            end

            FILL: begin
                c_w_rd    = 1'b1;
                c_data_oe = 1'b1;
                c_wdata   = we_q ? wdata_q : data_q;
                state_d   = we_q ? MREQ : DONE;
            end

            DONE: begin
                cpu_done  = 1'b1;
                cpu_rdata = data_q;
                cpu_err   = err_q;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control registers: captured request, error flag, timeout, counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= 16'h0000;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            tmo_q    <= 16'h0000;
            hit_cnt  <= 16'h0000;
            miss_cnt <= 16'h0000;
        end else begin
            if (accept) begin
                addr_q <= cpu_addr;
                we_q   <= cpu_we;
            end

            if (tmo_ev) begin
                err_q <= 1'b1;
            end else if (accept || state_q == DONE) begin
                err_q <= 1'b0;
            end

            // Held at zero outside MREQ, so it starts from zero on every entry.
            if (state_q != MREQ) begin
                tmo_q <= 16'h0000;
            end else if (!mem_ack) begin
                tmo_q <= tmo_q + 16'd1;
            end

            if (hit_ev) begin
                hit_cnt <= sat_inc(hit_cnt);
            end
            if (miss_ev) begin
                miss_cnt <= sat_inc(miss_cnt);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Data registers: write byte and returned byte. Both only reach the
    // outputs through state-gated paths, so they carry no reset. The returned
    // byte is cleared at accept so writes and timeouts report 0x00.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            wdata_q <= cpu_wdata;
            data_q  <= 8'h00;
        end else if (hit_ev) begin
            data_q <= c_rdata;
        end else if (ack_ev && !we_q) begin
            data_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_fill_ctrl
//
// Bench for cache_fill_ctrl with TIMEOUT = 4. A behavioural 128-byte
// direct-mapped cache and a main-memory responder surround the controller.
// Each CPU request pushes its expected completion (data, error, completion
// cycle) into a queue; a monitor pops and compares on every cpu_done.
// -----------------------------------------------------------------------------
module tb_cache_fill_ctrl;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_done;
    logic        cpu_err;
    logic [15:0] c_address;
    logic        c_w_rd;
    logic        c_hit;
    logic [7:0]  c_rdata;
    logic [7:0]  c_wdata;
    logic        c_data_oe;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    cache_fill_ctrl #(.TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_done  (cpu_done),
        .cpu_err   (cpu_err),
        .c_address (c_address),
        .c_w_rd    (c_w_rd),
        .c_hit     (c_hit),
        .c_rdata   (c_rdata),
        .c_wdata   (c_wdata),
        .c_data_oe (c_data_oe),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- cache model ----------------
    logic [8:0] tag_arr [128];
    logic       vld_arr [128];
    logic [7:0] dat_arr [128];

    initial begin
        for (int i = 0; i < 128; i++) begin
            vld_arr[i] = 1'b0;
            tag_arr[i] = 9'h000;
            dat_arr[i] = 8'h00;
        end
        vld_arr[0] = 1'b1;
        tag_arr[0] = 9'h000;
        dat_arr[0] = 8'h69;
        c_hit      = 1'b0;
        c_rdata    = 8'h00;
    end

    always @(posedge clk) begin
        if (c_w_rd === 1'b1) begin
            if (c_data_oe === 1'b1) begin
                dat_arr[c_address[6:0]] <= c_wdata;
                tag_arr[c_address[6:0]] <= c_address[15:7];
                vld_arr[c_address[6:0]] <= 1'b1;
            end
        end else begin
            c_hit   <= vld_arr[c_address[6:0]] && (tag_arr[c_address[6:0]] == c_address[15:7]);
            c_rdata <= dat_arr[c_address[6:0]];
        end
    end

    // ---------------- memory model ----------------
    logic        ack_en = 1'b1;
    int          ack_delay = 0;
    logic [7:0]  ack_data = 8'h00;
    logic        model_ack = 1'b0;
    logic        late_ack = 1'b0;
    int          req_cnt = 0;
    int          req_total = 0;
    int          last_req_len = 0;
    logic [15:0] exp_mem_addr = 16'h0000;
    logic        exp_mem_we = 1'b0;
    logic [7:0]  exp_mem_wdata = 8'h00;

    assign mem_ack = model_ack | late_ack;

    always @(negedge clk) begin
        if (mem_req === 1'b1) begin
            chk("mem_addr", 32'(mem_addr), 32'(exp_mem_addr));
            chk("mem_we", 32'(mem_we), 32'(exp_mem_we));
            if (exp_mem_we) chk("mem_wdata", 32'(mem_wdata), 32'(exp_mem_wdata));
            model_ack = ack_en && (req_cnt == ack_delay);
            mem_rdata = ack_data;
            req_cnt++;
            req_total++;
        end else begin
            if (req_cnt != 0) last_req_len = req_cnt;
            req_cnt   = 0;
            model_ack = 1'b0;
        end
    end

    // ---------------- scoreboard / monitors ----------------
    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         done_cyc;
    } exp_t;

    exp_t        sb_q [$];
    logic [7:0]  exp_fill = 8'h00;
    logic [15:0] exp_c_addr = 16'h0000;
    int          fill_cnt = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst !== 1'b1 && cpu_done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: cpu_done=1 with nothing outstanding (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                chk("done_rdata", 32'(cpu_rdata), 32'(e.rdata));
                chk("done_err", 32'(cpu_err), 32'(e.err));
                chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
            end
        end
        if (c_data_oe === 1'b1) begin
            chk("fill_wdata", 32'(c_wdata), 32'(exp_fill));
            chk("fill_addr", 32'(c_address), 32'(exp_c_addr));
            chk("fill_w_rd", 32'(c_w_rd), 32'd1);
            fill_cnt++;
        end else if (c_w_rd !== 1'b0) begin
            chk("w_rd_outside_fill", 32'(c_w_rd), 32'd0);
        end
    end

    // ---------------- driver ----------------
    task automatic do_req(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                          input logic [7:0] exp_rd, input logic exp_err, input int lat);
        exp_t e;
        int   n;
        @(negedge clk);
        cpu_req       = 1'b1;
        cpu_we        = we;
        cpu_addr      = addr;
        cpu_wdata     = wd;
        exp_mem_addr  = addr;
        exp_mem_we    = we;
        exp_mem_wdata = wd;
        exp_c_addr    = addr;
        exp_fill      = we ? wd : ack_data;
        e.rdata       = exp_rd;
        e.err         = exp_err;
        e.done_cyc    = cyc + 1 + lat;
        sb_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cpu_done !== 1'b1 && n < 100);
        if (cpu_done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_wait: no cpu_done for addr 0x%0h within %0d cycles", addr, n);
        end
        cpu_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rb;
        int fb;
        int n;

        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
        mem_rdata = 8'h00;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_done", 32'(cpu_done), 32'd0);
        chk("rst_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_err", 32'(cpu_err), 32'd0);
        chk("rst_c_address", 32'(c_address), 32'd0);
        chk("rst_c_w_rd", 32'(c_w_rd), 32'd0);
        chk("rst_c_data_oe", 32'(c_data_oe), 32'd0);
        chk("rst_c_wdata", 32'(c_wdata), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Hit on preloaded line
        rb = req_total;
        do_req(1'b0, 16'h0000, 8'h00, 8'h69, 1'b0, 2);
        chk("hit0_hit_cnt", 32'(hit_cnt), 32'd1);
        chk("hit0_miss_cnt", 32'(miss_cnt), 32'd0);
        chk("hit0_no_mem_req", 32'(req_total), 32'(rb));

        // Read miss, memory acks three cycles after mem_req
        ack_en = 1'b1; ack_delay = 3; ack_data = 8'hA5;
        fb = fill_cnt;
        do_req(1'b0, 16'h1234, 8'h00, 8'hA5, 1'b0, 7);
        chk("miss_miss_cnt", 32'(miss_cnt), 32'd1);
        chk("miss_req_len", 32'(last_req_len), 32'd4);
        chk("miss_fill_cnt", 32'(fill_cnt - fb), 32'd1);

        // Filled line now hits
        do_req(1'b0, 16'h1234, 8'h00, 8'hA5, 1'b0, 2);
        chk("refill_hit_cnt", 32'(hit_cnt), 32'd2);

        // Write-through, memory acks one cycle after mem_req
        ack_delay = 1;
        fb = fill_cnt;
        do_req(1'b1, 16'h0080, 8'h5A, 8'h00, 1'b0, 3);
        chk("wr_fill_cnt", 32'(fill_cnt - fb), 32'd1);
        chk("wr_req_len", 32'(last_req_len), 32'd2);
        chk("wr_hit_cnt", 32'(hit_cnt), 32'd2);
        chk("wr_miss_cnt", 32'(miss_cnt), 32'd1);

        do_req(1'b0, 16'h0080, 8'h00, 8'h5A, 1'b0, 2);
        chk("wr_rd_hit_cnt", 32'(hit_cnt), 32'd3);

        // Fastest miss: 0x0000 was evicted by the write to 0x0080
        ack_delay = 0; ack_data = 8'h3C;
        do_req(1'b0, 16'h0000, 8'h00, 8'h3C, 1'b0, 4);
        chk("fast_miss_cnt", 32'(miss_cnt), 32'd2);

        // Timeout: no ack at all
        ack_en = 1'b0; ack_data = 8'hEE;
        fb = fill_cnt;
        do_req(1'b0, 16'h4321, 8'h00, 8'h00, 1'b1, 6);
        chk("tmo_req_len", 32'(last_req_len), 32'(TMO));
        chk("tmo_no_fill", 32'(fill_cnt - fb), 32'd0);
        chk("tmo_miss_cnt", 32'(miss_cnt), 32'd3);

        // Same address misses again
        ack_en = 1'b1; ack_delay = 0; ack_data = 8'h77;
        do_req(1'b0, 16'h4321, 8'h00, 8'h77, 1'b0, 4);
        chk("tmo_reread_miss_cnt", 32'(miss_cnt), 32'd4);
        chk("tmo_reread_hit_cnt", 32'(hit_cnt), 32'd3);

        // Reset in the middle of a memory request
        ack_en = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0F00;
        exp_mem_addr = 16'h0F00; exp_mem_we = 1'b0; exp_c_addr = 16'h0F00;
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rstm_reached_mreq", 32'(mem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstm_mem_req", 32'(mem_req), 32'd0);
        chk("rstm_done", 32'(cpu_done), 32'd0);
        chk("rstm_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("rstm_miss_cnt", 32'(miss_cnt), 32'd0);
        cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        late_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("late_ack_mem_req", 32'(mem_req), 32'd0);
            chk("late_ack_done", 32'(cpu_done), 32'd0);
        end
        late_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_miss_cnt", 32'(miss_cnt), 32'd0);

        // Hit counter saturation
        force dut.hit_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.hit_cnt;
        ack_en = 1'b1;
        do_req(1'b0, 16'h1234, 8'h00, 8'hA5, 1'b0, 2);
        chk("sat_hit1", 32'(hit_cnt), 32'hFFFF);
        do_req(1'b0, 16'h1234, 8'h00, 8'hA5, 1'b0, 2);
        chk("sat_hit2", 32'(hit_cnt), 32'hFFFF);
        do_req(1'b0, 16'h1234, 8'h00, 8'hA5, 1'b0, 2);
        chk("sat_hit3", 32'(hit_cnt), 32'hFFFF);
        chk("sat_miss_cnt", 32'(miss_cnt), 32'd0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
